// File: rtl/utm_pkg.sv
// Shared types and constants for the universal Turing machine datapath.
package utm_pkg;

  localparam int unsigned SYM_W = 3;
  localparam logic [SYM_W-1:0] SYM_BLANK   = 3'b000;
  localparam logic [SYM_W-1:0] SYM_ILLEGAL = 3'b011;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    READY = 2'd0,
    MOVE  = 2'd1,
    FETCH = 2'd2,
    FAULT = 2'd3
  } tape_state_t;

  // The one unencodable symbol is stored as BLANK so the tape never holds it.
  function automatic logic [SYM_W-1:0] sanitize_sym(input logic [SYM_W-1:0] s);
    return (s == SYM_ILLEGAL) ? SYM_BLANK : s;
  endfunction

endpackage

// File: rtl/tape_ram.sv
// Tape cell array: one synchronous write port with synchronous clear, one async read port.
module tape_ram
  import utm_pkg::*;
#(
  parameter int CELLS = 16,
  parameter int AW    = $clog2(CELLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [SYM_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [SYM_W-1:0] rdata_o
);

  logic [SYM_W-1:0] mem_q [CELLS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) mem_q[i] <= SYM_BLANK;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tape_unit.sv
// Tape and head: accepts one step per handshake (write under head, move, fetch next symbol).
module tape_unit
  import utm_pkg::*;
#(
  parameter int CELLS = 16,
  parameter int HOME  = CELLS / 2,
  localparam int AW   = $clog2(CELLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [SYM_W-1:0] load_sym,
  input  logic             step_valid,
  input  logic [SYM_W-1:0] new_sym,
  input  logic             move_right,
  output logic             step_ready,
  output logic [SYM_W-1:0] sym_out,
  output logic [AW-1:0]    head_pos,
  output logic             edge_fault,
  output logic             bad_sym,
  output tape_state_t      dbg_state
);

  // Handshake: a step is accepted on a rising edge where step_valid && step_ready;
  // step_ready is high only in READY, so holding step_valid high never double-accepts.

  localparam logic [AW-1:0] HEAD_HOME = AW'(HOME);
  localparam logic [AW-1:0] HEAD_LAST = AW'(CELLS - 1);
  localparam logic [AW-1:0] HEAD_ONE  = AW'(1);

  tape_state_t      state_q, state_d;
  logic [AW-1:0]    head_q, head_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             dir_q, dir_d;
  logic             edge_fault_q, edge_fault_d;
  logic             bad_sym_q, bad_sym_d;

  logic             accept;
  logic             load_ok;
  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [SYM_W-1:0] wr_raw;
  logic [SYM_W-1:0] wr_sym;
  logic [SYM_W-1:0] rd_sym;
  logic             at_edge;

  assign accept  = (state_q == READY) && step_valid;
  assign load_ok = (state_q == READY) && load_en && !step_valid;

  // Step write takes the port over load; loads only win when no step is offered.
  assign ram_we    = accept || load_ok;
  assign ram_waddr = accept ? head_q : load_addr;
  assign wr_raw    = accept ? new_sym : load_sym;
  assign wr_sym    = sanitize_sym(wr_raw);

  assign at_edge = (dir_q == DIR_RIGHT) ? (head_q == HEAD_LAST) : (head_q == '0);

  tape_ram #(
    .CELLS (CELLS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (wr_sym),
    .raddr_i (head_q),
    .rdata_o (rd_sym)
  );

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    sym_d        = sym_q;
    dir_d        = dir_q;
    edge_fault_d = edge_fault_q;
    bad_sym_d    = bad_sym_q;
    case (state_q)
      READY: begin
        if (accept) begin
          state_d = MOVE;
          dir_d   = move_right;
        end
      end
      MOVE: begin
        if (at_edge) begin
          state_d      = FAULT;
          edge_fault_d = 1'b1;
        end else begin
          state_d = FETCH;
          head_d  = (dir_q == DIR_RIGHT) ? head_q + HEAD_ONE : head_q - HEAD_ONE;
        end
      end
      FETCH: begin
        state_d = READY;
        sym_d   = rd_sym;
      end
      default: state_d = FAULT;
    endcase
    if (load_ok && (load_addr == head_q)) sym_d = wr_sym;
    if (ram_we && (wr_raw == SYM_ILLEGAL)) bad_sym_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= READY;
      head_q       <= HEAD_HOME;
      sym_q        <= SYM_BLANK;
      dir_q        <= DIR_LEFT;
      edge_fault_q <= 1'b0;
      bad_sym_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      sym_q        <= sym_d;
      dir_q        <= dir_d;
      edge_fault_q <= edge_fault_d;
      bad_sym_q    <= bad_sym_d;
    end
  end

  assign step_ready = (state_q == READY);
  assign sym_out    = sym_q;
  assign head_pos   = head_q;
  assign edge_fault = edge_fault_q;
  assign bad_sym    = bad_sym_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tape_unit.sv
// Directed bench for tape_unit: step completions are checked by a scoreboard monitor.
module tb_tape_unit;
  import utm_pkg::*;

  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load_en = 1'b0;
  logic [AW-1:0]   load_addr = '0;
  logic [2:0]      load_sym = '0;
  logic            step_valid = 1'b0;
  logic [2:0]      new_sym = '0;
  logic            move_right = 1'b0;
  logic            step_ready;
  logic [2:0]      sym_out;
  logic [AW-1:0]   head_pos;
  logic            edge_fault;
  logic            bad_sym;
  tape_state_t     dbg_state;

  int total = 0;
  int bad = 0;

  // expected completion: {head_pos, sym_out, bad_sym}
  logic [7:0] exp_q[$];

  tape_unit #(.CELLS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_sym   (load_sym),
    .step_valid (step_valid),
    .new_sym    (new_sym),
    .move_right (move_right),
    .step_ready (step_ready),
    .sym_out    (sym_out),
    .head_pos   (head_pos),
    .edge_fault (edge_fault),
    .bad_sym    (bad_sym),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  logic        rst_at_edge = 1'b0;
  tape_state_t prev_state = READY;

  always @(posedge clk) rst_at_edge <= reset;

  always @(negedge clk) begin
    if (prev_state == FETCH && dbg_state == READY && !rst_at_edge) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", {24'd0, head_pos, sym_out, bad_sym}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("step_result", {24'd0, head_pos, sym_out, bad_sym}, {24'd0, e});
      end
    end
    prev_state = dbg_state;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!step_ready && n < 20) begin
      tick();
      n++;
    end
    if (!step_ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [2:0] s);
    load_en = 1'b1;
    load_addr = a;
    load_sym = s;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_step(input logic [2:0] s, input logic dir,
                         input logic [AW-1:0] e_head, input logic [2:0] e_sym,
                         input logic e_bad);
    wait_ready();
    step_valid = 1'b1;
    new_sym = s;
    move_right = dir;
    exp_q.push_back({e_head, e_sym, e_bad});
    tick();
    step_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int accepts;
    tick();
    reset = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_head", 32'(head_pos), 32'd8);
    chk("rst_sym", 32'(sym_out), 32'd0);
    chk("rst_ready", 32'(step_ready), 32'd1);
    chk("rst_edge", 32'(edge_fault), 32'd0);
    chk("rst_bad", 32'(bad_sym), 32'd0);

    // load then step right, step back to read cell 8
    do_load(4'd8, 3'b101);
    chk("load_head_sym", 32'(sym_out), 32'b101);
    do_load(4'd9, 3'b110);
    chk("load_other_sym", 32'(sym_out), 32'b101);
    do_step(3'b010, DIR_RIGHT, 4'd9, 3'b110, 1'b0);
    do_step(3'b110, DIR_LEFT, 4'd8, 3'b010, 1'b0);

    // walk to the left edge then fault
    do_reset();
    for (int i = 0; i < 8; i++) do_step(3'b000, DIR_LEFT, 4'(7 - i), 3'b000, 1'b0);
    chk("edge0_fault", 32'(edge_fault), 32'd0);
    wait_ready();
    step_valid = 1'b1;
    move_right = DIR_LEFT;
    tick();
    step_valid = 1'b0;
    tick();
    chk("fault_flag", 32'(edge_fault), 32'd1);
    chk("fault_ready", 32'(step_ready), 32'd0);
    chk("fault_head", 32'(head_pos), 32'd0);
    chk("fault_state", 32'(dbg_state), 32'(FAULT));
    step_valid = 1'b1;
    load_en = 1'b1;
    load_addr = 4'd0;
    load_sym = 3'b111;
    tick(); tick(); tick();
    step_valid = 1'b0;
    load_en = 1'b0;
    chk("fault_hold_ready", 32'(step_ready), 32'd0);
    chk("fault_hold_head", 32'(head_pos), 32'd0);
    chk("fault_load_drop", 32'(sym_out), 32'd0);
    do_reset();
    chk("post_fault_head", 32'(head_pos), 32'd8);
    chk("post_fault_edge", 32'(edge_fault), 32'd0);
    chk("post_fault_ready", 32'(step_ready), 32'd1);

    // illegal symbol by step, then legal steps
    do_step(3'b011, DIR_RIGHT, 4'd9, 3'b000, 1'b1);
    do_step(3'b001, DIR_LEFT, 4'd8, 3'b000, 1'b1);
    do_step(3'b101, DIR_RIGHT, 4'd9, 3'b001, 1'b1);

    // illegal symbol by load
    do_reset();
    do_load(4'd8, 3'b111);
    chk("load_legal_sym", 32'(sym_out), 32'b111);
    chk("load_legal_bad", 32'(bad_sym), 32'd0);
    do_load(4'd8, 3'b011);
    chk("load_illegal_sym", 32'(sym_out), 32'd0);
    chk("load_illegal_bad", 32'(bad_sym), 32'd1);

    // step_valid held for 9 cycles
    do_reset();
    exp_q.push_back({4'd9, 3'b000, 1'b0});
    exp_q.push_back({4'd8, 3'b100, 1'b0});
    exp_q.push_back({4'd9, 3'b100, 1'b0});
    accepts = 0;
    step_valid = 1'b1;
    new_sym = 3'b100;
    for (int i = 0; i < 9; i++) begin
      move_right = (i % 2 == 0) ? DIR_RIGHT : DIR_LEFT;
      chk("held_ready", 32'(step_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
      if (step_ready) accepts++;
      tick();
    end
    step_valid = 1'b0;
    chk("held_accepts", 32'(accepts), 32'd3);

    // load during MOVE is dropped
    do_reset();
    step_valid = 1'b1;
    new_sym = 3'b000;
    move_right = DIR_RIGHT;
    exp_q.push_back({4'd9, 3'b000, 1'b0});
    tick();
    step_valid = 1'b0;
    load_en = 1'b1;
    load_addr = 4'd9;
    load_sym = 3'b111;
    tick();
    load_en = 1'b0;
    tick();

    // reset during FETCH clears tape and aborts the step
    do_reset();
    do_load(4'd9, 3'b111);
    wait_ready();
    step_valid = 1'b1;
    new_sym = 3'b101;
    move_right = DIR_RIGHT;
    tick();
    step_valid = 1'b0;
    tick();
    chk("pre_abort_state", 32'(dbg_state), 32'(FETCH));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_state", 32'(dbg_state), 32'(READY));
    chk("abort_head", 32'(head_pos), 32'd8);
    chk("abort_sym", 32'(sym_out), 32'd0);
    do_step(3'b000, DIR_RIGHT, 4'd9, 3'b000, 1'b0);
    do_step(3'b000, DIR_LEFT, 4'd8, 3'b000, 1'b0);

    // final report
    tick();
    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tape_unit.md
# tape_unit

Tape storage and head for the universal Turing machine. It holds a bounded tape of 3-bit symbols and presents the symbol under the head to the new-symbol and next-state logic. It accepts one step per handshake: write the computed new symbol, move the head, then fetch the next symbol. It sits directly upstream and downstream of the new-symbol stage, feeding its `s2..s0` inputs and consuming its `z2..z0` outputs.

## Interface
- `CELLS`, default 16: number of tape cells; must be ≥ 2 and a power of two.
- `HOME`, default `CELLS/2`: head position after reset.
- `clk`, input, 1: the block's only clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `load_en`, input, 1: writes the initial tape contents one cell per cycle.
- `load_addr`, input, `$clog2(CELLS)`: cell index for a load.
- `load_sym`, input, 3: symbol for a load.
- `step_valid`, input, 1: a step request is present.
- `new_sym`, input, 3: symbol to write under the head; comes from new-symbol `z2..z0`.
- `move_right`, input, 1: head direction; 1 = right (+1), 0 = left (−1).
- `step_ready`, output, 1: the unit is ready to accept a step.
- `sym_out`, output, 3: symbol under the head, registered; goes to new-symbol `s2..s0`.
- `head_pos`, output, `$clog2(CELLS)`: current head index.
- `edge_fault`, output, 1: sticky; the head tried to move off the tape.
- `bad_sym`, output, 1: sticky; an illegal symbol `3'b011` was written.

## Operation
- FSM states:
  - READY: `step_ready` = 1.
  - MOVE
  - FETCH
  - FAULT: `step_ready` = 0.
- READY → MOVE on `step_valid && step_ready`. On the same edge, `cell[head_pos] <= new_sym`, and `move_right` is captured.
- MOVE → FETCH:
  - In range: `head_pos` ± 1.
  - Move left at index 0, or right at index `CELLS-1`: go to FAULT instead. `head_pos` is unchanged and `edge_fault` is set.
- FETCH → READY: `sym_out <= cell[head_pos]`.
- FAULT is held until `reset`. Steps are ignored while in FAULT.
- Legal symbols: `000`, `001`, `010`, `100`, `101`, `110`, `111`. `000` is BLANK.
- Writing `011`, by step or by load, stores BLANK and sets `bad_sym`.
- Loads:
  - Honoured only in READY with `step_valid` = 0. Loads in other states, or together with `step_valid`, are dropped.
  - A load to `head_pos` also updates `sym_out` on the same edge.
- Outputs in READY are stable; `sym_out` changes only in FETCH or on a load to the head cell.

## Timing
- Reset values:
  - All cells = BLANK.
  - `head_pos` = `HOME`.
  - `sym_out` = `000`.
  - `step_ready` = 1 (state READY).
  - `edge_fault` = 0 and `bad_sym` = 0.
- Step latency: request accepted at edge N; head moves at N+1; new `sym_out` valid and `step_ready` = 1 after edge N+2. Throughput is one step per 3 cycles.
- `step_ready` is low from the accept edge until the FETCH edge completes; it is 0 in MOVE and FETCH.
- `step_valid` held high across the busy cycles does not cause a second accept before READY.
- Combinational loop: the upstream `new_sym` is a function of `sym_out`. Since `sym_out` is registered, there is no loop.
- Reset during MOVE or FETCH aborts the step. The tape is cleared. A write already done at the accept edge is discarded by the clear.
- Reset has priority over load and step in the same cycle.

## Structure
- Shared package `utm_pkg`:
  - `SYM_W = 3`
  - `SYM_BLANK = 3'b000`
  - `SYM_ILLEGAL = 3'b011`
  - `DIR_LEFT = 1'b0`, `DIR_RIGHT = 1'b1`
  - `tape_state_t` enum {READY, MOVE, FETCH, FAULT}
- One sub-module, `tape_ram`:
  - `CELLS × SYM_W` register array.
  - One synchronous write port with sync clear on `reset`.
  - One asynchronous read port.
- Illegal-symbol sanitising and the write-port mux (load vs step) live in `tape_unit`.

## Test plan
- Reset, then idle 2 cycles → `head_pos` = 8, `sym_out` = `000`, `step_ready` = 1, both flags 0.
- Load `cell[8] = 101` and `cell[9] = 110`; then step with `new_sym` = `010`, `move_right` = 1 → after 3 cycles `head_pos` = 9, `sym_out` = `110`, and `cell[8]` reads back `010`.
- Reset; step left 8 times → `head_pos` = 0, no fault. The 9th left step → FAULT, `edge_fault` = 1, `step_ready` stays 0, `head_pos` = 0. Then `reset` → READY, `head_pos` = 8.
- Step with `new_sym` = `011` → `bad_sym` = 1 and the written cell reads `000`. A following legal step still completes normally.
- Hold `step_valid` = 1 for 9 cycles alternating direction → exactly 3 accepts, `step_ready` pattern 1,0,0 repeating. Also check that a load asserted during MOVE is dropped.
- Assert `reset` in the FETCH cycle of a step → next cycle READY, all cells BLANK, `sym_out` = `000`.
